cell_render_queue: RTL and testbench

Sits directly downstream of the grid frame tracker. It captures every changed cell reported by the tracker (diff, x, y, obj_code) into a small FIFO. Each queued cell becomes an LCD draw sequence: column window, page window, RAM write, then CELL_W*CELL_H colour words. It throttles the tracker scan through scan_en so the FIFO does not overflow in normal operation.

---
 rtl/cell_render_queue.sv | 185 ++++++++++++++++++
 tb/tb_cell_render_queue.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cell_render_queue.sv
// Purpose: queues changed grid cells from the frame tracker and expands each into an LCD
//          draw sequence (CASET x0 x1, PASET y0 y1, RAMWR, CELL_W*CELL_H colour words).
// Latency: diff at edge k -> pop at edge k+1 -> first command word valid after edge k+2.
// Backpressure: words are held until out_valid && out_ready; scan_en throttles the tracker.
// Ports: clk/nrst (async active-low); diff,x,y,obj_code = tracker cell report;
//        scan_en = tracker scan enable; out_valid/out_ready/out_is_cmd/out_data = LCD word
//        stream; busy = work pending; overflow = sticky dropped-push flag.
module cell_render_queue #(
  parameter int          DEPTH      = 4,
  parameter int          CELL_W     = 20,
  parameter int          CELL_H     = 20,
  parameter logic [15:0] COL_EMPTY  = 16'h0000,
  parameter logic [15:0] COL_SNAKE  = 16'h07E0,
  parameter logic [15:0] COL_APPLE  = 16'hF800,
  parameter logic [15:0] COL_BORDER = 16'hFFFF
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        diff,
  input  logic [3:0]  x,
  input  logic [3:0]  y,
  input  logic [1:0]  obj_code,
  output logic        scan_en,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_is_cmd,
  output logic [15:0] out_data,
  output logic        busy,
  output logic        overflow
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] SCAN_MAX = (AW+1)'(DEPTH - 2);
  localparam logic [15:0] CW       = 16'(CELL_W);
  localparam logic [15:0] CH       = 16'(CELL_H);
  localparam logic [15:0] PIX_LAST = 16'(CELL_W * CELL_H - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CASET, S_XS, S_XE, S_PASET, S_YS, S_YE, S_RAMWR, S_PIX
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [9:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          overflow_q;

  state_t        state_q;
  logic          load_q;     // head popped into working regs, CASET issued next edge
  logic [3:0]    wx_q, wy_q;
  logic [1:0]    wcode_q;
  logic [15:0]   pix_q;
  logic          out_valid_q, out_is_cmd_q;
  logic [15:0]   out_data_q;

  logic          full, pop, push, hs;
  logic [9:0]    head;

  assign full = (count_q == FULL_CNT);
  assign pop  = (state_q == S_IDLE) && !load_q && (count_q != '0);
  // A full FIFO still accepts a push when the same edge pops an entry.
  assign push = diff && (!full || pop);
  assign head = mem_q[rd_ptr_q];
  assign hs   = out_valid_q && out_ready;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {x, y, obj_code};
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (diff && full && !pop) overflow_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------- geometry
  logic [15:0] x0, x1, y0, y1, colour;

  assign x0 = {12'd0, wx_q} * CW;
  assign x1 = x0 + CW - 16'd1;
  assign y0 = {12'd0, wy_q} * CH;
  assign y1 = y0 + CH - 16'd1;

  always_comb begin
    colour = COL_EMPTY;
    case (wcode_q)
      2'b00:   colour = COL_EMPTY;
      2'b01:   colour = COL_SNAKE;
      2'b10:   colour = COL_APPLE;
      default: colour = COL_BORDER;
    endcase
  end

  // --------------------------------------------------------------- FSM
  // Outputs are registered: each handshake loads the word for the state being entered.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= S_IDLE;
      load_q       <= 1'b0;
      wx_q         <= '0;
      wy_q         <= '0;
      wcode_q      <= '0;
      pix_q        <= '0;
      out_valid_q  <= 1'b0;
      out_is_cmd_q <= 1'b0;
      out_data_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load_q) begin
            load_q       <= 1'b0;
            state_q      <= S_CASET;
            out_valid_q  <= 1'b1;
            out_is_cmd_q <= 1'b1;
            out_data_q   <= 16'h002A;
          end else if (pop) begin
            wx_q    <= head[9:6];
            wy_q    <= head[5:2];
            wcode_q <= head[1:0];
            load_q  <= 1'b1;
          end
        end
        S_CASET: if (hs) begin
          state_q <= S_XS;  out_is_cmd_q <= 1'b0; out_data_q <= x0;
        end
        S_XS: if (hs) begin
          state_q <= S_XE;  out_is_cmd_q <= 1'b0; out_data_q <= x1;
        end
        S_XE: if (hs) begin
          state_q <= S_PASET; out_is_cmd_q <= 1'b1; out_data_q <= 16'h002B;
        end
        S_PASET: if (hs) begin
          state_q <= S_YS;  out_is_cmd_q <= 1'b0; out_data_q <= y0;
        end
        S_YS: if (hs) begin
          state_q <= S_YE;  out_is_cmd_q <= 1'b0; out_data_q <= y1;
        end
        S_YE: if (hs) begin
          state_q <= S_RAMWR; out_is_cmd_q <= 1'b1; out_data_q <= 16'h002C;
        end
        S_RAMWR: if (hs) begin
          state_q <= S_PIX; out_is_cmd_q <= 1'b0; out_data_q <= colour;
          pix_q   <= '0;
        end
        S_PIX: if (hs) begin
          if (pix_q == PIX_LAST) begin
            pix_q        <= '0;
            state_q      <= S_IDLE;
            out_valid_q  <= 1'b0;
            out_is_cmd_q <= 1'b0;
            out_data_q   <= '0;
          end else begin
            pix_q <= pix_q + 16'd1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign scan_en    = (count_q <= SCAN_MAX);
  assign out_valid  = out_valid_q;
  assign out_is_cmd = out_is_cmd_q;
  assign out_data   = out_data_q;
  // The popped-but-not-yet-drawn cycle still counts as outstanding work.
  assign busy       = (state_q != S_IDLE) || load_q || (count_q != '0);
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_cell_render_queue.sv
module tb_cell_render_queue;

  logic        clk, nrst, diff, out_ready;
  logic [3:0]  x, y;
  logic [1:0]  obj_code;
  logic        scan_en, out_valid, out_is_cmd, busy, overflow;
  logic [15:0] out_data;

  int checks;
  int failures;
  logic [16:0] cap [0:7];

  cell_render_queue dut (
    .clk(clk), .nrst(nrst), .diff(diff), .x(x), .y(y), .obj_code(obj_code),
    .scan_en(scan_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_is_cmd(out_is_cmd), .out_data(out_data), .busy(busy), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] col(input int c);
    case (c)
      0:       return 16'h0000;
      1:       return 16'h07E0;
      2:       return 16'hF800;
      default: return 16'hFFFF;
    endcase
  endfunction

  // Expected {is_cmd, data} for word n of a cell's draw sequence.
  function automatic logic [16:0] expw(input int ex, input int ey, input int ec, input int n);
    case (n)
      0:       return {1'b1, 16'h002A};
      1:       return {1'b0, 16'(ex * 20)};
      2:       return {1'b0, 16'(ex * 20 + 19)};
      3:       return {1'b1, 16'h002B};
      4:       return {1'b0, 16'(ey * 20)};
      5:       return {1'b0, 16'(ey * 20 + 19)};
      6:       return {1'b1, 16'h002C};
      default: return {1'b0, col(ec)};
    endcase
  endfunction

  task automatic push_cell(input int cx, input int cy, input int cc);
    diff     = 1'b1;
    x        = 4'(cx);
    y        = 4'(cy);
    obj_code = 2'(cc);
    tick();
    diff     = 1'b0;
  endtask

  // Consume one complete cell (7 + 400 words) and compare it against the expected stream.
  task automatic draw_cell(input int ex, input int ey, input int ec, input bit rnd, input string tag);
    int n, bad, unstable, cyc;
    logic pv;
    logic [16:0] prev;
    n = 0; bad = 0; unstable = 0; cyc = 0; pv = 1'b0; prev = '0;
    while (n < 407 && cyc < 4000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pv && ({out_valid, out_is_cmd, out_data} !== {1'b1, prev})) unstable++;
      pv = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          if ({out_is_cmd, out_data} !== expw(ex, ey, ec, n)) bad++;
          if (n < 8) cap[n] = {out_is_cmd, out_data};
          n++;
        end else begin
          pv   = 1'b1;
          prev = {out_is_cmd, out_data};
        end
      end
      tick();
      cyc++;
    end
    chk({tag, " word_count"}, n, 407);
    chk({tag, " bad_words"}, bad, 0);
    chk({tag, " unstable"}, unstable, 0);
    chk({tag, " idle_after"}, out_valid, 0);
    out_ready = 1'b1;
  endtask

  initial begin
    int n, cyc, seen;
    checks = 0; failures = 0;
    nrst = 1'b0; diff = 1'b0; x = '0; y = '0; obj_code = '0; out_ready = 1'b0;
    repeat (3) tick();
    chk("rst scan_en",    scan_en,    1);
    chk("rst out_valid",  out_valid,  0);
    chk("rst out_is_cmd", out_is_cmd, 0);
    chk("rst out_data",   out_data,   0);
    chk("rst busy",       busy,       0);
    chk("rst overflow",   overflow,   0);
    nrst = 1'b1;
    tick();

    // Single cell, latency and exact window words.
    push_cell(3, 2, 1);
    chk("t1 busy k",   busy,      1);
    chk("t1 valid k",  out_valid, 0);
    tick();
    chk("t1 valid k+1", out_valid, 0);
    tick();
    chk("t1 valid k+2", out_valid,  1);
    chk("t1 cmd k+2",   out_is_cmd, 1);
    chk("t1 data k+2",  out_data,   16'h002A);
    draw_cell(3, 2, 1, 1'b0, "t1");
    chk("t1 xs",  cap[1], {1'b0, 16'd60});
    chk("t1 xe",  cap[2], {1'b0, 16'd79});
    chk("t1 ys",  cap[4], {1'b0, 16'd40});
    chk("t1 ye",  cap[5], {1'b0, 16'd59});
    chk("t1 ramwr", cap[6], {1'b1, 16'h002C});
    chk("t1 pix", cap[7], {1'b0, 16'h07E0});
    chk("t1 busy end", busy, 0);

    // Bottom-right corner cell.
    push_cell(15, 11, 3);
    draw_cell(15, 11, 3, 1'b0, "t2");
    chk("t2 xs",  cap[1], {1'b0, 16'd300});
    chk("t2 xe",  cap[2], {1'b0, 16'd319});
    chk("t2 ys",  cap[4], {1'b0, 16'd220});
    chk("t2 ye",  cap[5], {1'b0, 16'd239});
    chk("t2 pix", cap[7], {1'b0, 16'hFFFF});

    // Random backpressure.
    push_cell(5, 7, 2);
    draw_cell(5, 7, 2, 1'b1, "t3");
    chk("t3 xs",  cap[1], {1'b0, 16'd100});
    chk("t3 ye",  cap[5], {1'b0, 16'd159});
    chk("t3 pix", cap[7], {1'b0, 16'hF800});

    // FIFO fill and overflow while the FSM is stalled in CASET.
    out_ready = 1'b0;
    push_cell(0, 0, 0);
    tick(); tick();
    chk("t4 stalled valid", out_valid, 1);
    push_cell(1, 1, 1);  chk("t4 scan_en p1", scan_en, 1);
    push_cell(2, 2, 2);  chk("t4 scan_en p2", scan_en, 1);
    push_cell(3, 3, 3);  chk("t4 scan_en p3", scan_en, 0);
    push_cell(4, 4, 1);  chk("t4 scan_en p4", scan_en, 0);
    chk("t4 overflow p4", overflow, 0);
    push_cell(6, 6, 2);  chk("t4 overflow p5", overflow, 1);
    tick(); tick();
    chk("t4 held data", out_data, 16'h002A);
    draw_cell(0, 0, 0, 1'b0, "t4a");
    draw_cell(1, 1, 1, 1'b0, "t4b");
    draw_cell(2, 2, 2, 1'b0, "t4c");
    draw_cell(3, 3, 3, 1'b0, "t4d");
    draw_cell(4, 4, 1, 1'b0, "t4e");
    chk("t4 overflow sticky", overflow, 1);
    seen = 0;
    repeat (10) begin if (out_valid) seen++; tick(); end
    chk("t4 dropped not drawn", seen, 0);
    chk("t4 busy end", busy, 0);

    // Full FIFO with a push on the IDLE pop edge.
    nrst = 1'b0; tick(); nrst = 1'b1; tick();
    chk("t5 overflow cleared", overflow, 0);
    out_ready = 1'b0;
    push_cell(7, 1, 1);
    tick(); tick();
    push_cell(8, 2, 2);
    push_cell(9, 3, 3);
    push_cell(10, 4, 0);
    push_cell(11, 5, 1);
    chk("t5 full scan_en", scan_en, 0);
    chk("t5 full overflow", overflow, 0);
    draw_cell(7, 1, 1, 1'b0, "t5a");
    push_cell(12, 6, 2);
    chk("t5 pushpop overflow", overflow, 0);
    chk("t5 pushpop scan_en", scan_en, 0);
    draw_cell(8, 2, 2, 1'b0, "t5b");
    draw_cell(9, 3, 3, 1'b0, "t5c");
    draw_cell(10, 4, 0, 1'b0, "t5d");
    draw_cell(11, 5, 1, 1'b0, "t5e");
    draw_cell(12, 6, 2, 1'b0, "t5f");
    chk("t5 overflow end", overflow, 0);

    // Reset in the middle of PIX with a second cell queued.
    out_ready = 1'b1;
    push_cell(13, 8, 1);
    push_cell(14, 9, 3);
    n = 0; cyc = 0;
    while (n < 157 && cyc < 1000) begin
      if (out_valid && out_ready) n++;
      tick();
      cyc++;
    end
    chk("t6 reached pix150", n, 157);
    chk("t6 pix data", out_data, 16'h07E0);
    #2 nrst = 1'b0;
    #1;
    chk("t6 scan_en",    scan_en,    1);
    chk("t6 out_valid",  out_valid,  0);
    chk("t6 out_is_cmd", out_is_cmd, 0);
    chk("t6 out_data",   out_data,   0);
    chk("t6 busy",       busy,       0);
    chk("t6 overflow",   overflow,   0);
    tick();
    nrst = 1'b1;
    seen = 0;
    repeat (10) begin if (out_valid) seen++; tick(); end
    chk("t6 fifo flushed", seen, 0);
    chk("t6 busy idle", busy, 0);
    push_cell(2, 5, 2);
    draw_cell(2, 5, 2, 1'b0, "t6");
    chk("t6 first cmd", cap[0], {1'b1, 16'h002A});
    chk("t6 xs",        cap[1], {1'b0, 16'd40});
    chk("t6 ys",        cap[4], {1'b0, 16'd100});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
